// File: rtl/cd_pkg.sv
// Shared definitions for the CD request arbiter: requester indices, FSM states,
// HPS request codes and the fixed-priority grant helpers.
package cd_pkg;

  localparam logic [1:0] REQ_TOC   = 2'd0;
  localparam logic [1:0] REQ_DATA  = 2'd1;
  localparam logic [1:0] REQ_AUDIO = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_XFER  = 2'd2,
    ST_FLUSH = 2'd3
  } arb_state_e;

  localparam logic [15:0] HPS_TOC_FIRST_LAST  = 16'hD000;
  localparam logic [15:0] HPS_TOC_LENGTH      = 16'hD100;
  localparam logic [7:0]  HPS_TRACK_START_PFX = 8'hD2;

  // Audio outranks data, data outranks TOC.
  function automatic logic [1:0] prio_grant(input logic [2:0] valid);
    if (valid[REQ_AUDIO]) begin
      prio_grant = REQ_AUDIO;
    end else if (valid[REQ_DATA]) begin
      prio_grant = REQ_DATA;
    end else begin
      prio_grant = REQ_TOC;
    end
  endfunction

  function automatic logic [2:0] owner_mask(input logic [1:0] idx);
    owner_mask = 3'b001 << idx;
  endfunction

endpackage

// File: rtl/cd_arb_watchdog.sv
// Loadable down-counter with expiry flag; the arbiter instantiates it only when
// CD_ARB_TIMEOUT_EN is defined.
module cd_arb_watchdog #(
  parameter int WIDTH = 24
) (
  input  logic             clk_sys,
  input  logic             nRESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             run,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_r;

  // Reload wins over counting; the counter parks at zero.
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (run && (cnt_r != '0)) begin
      cnt_r <= cnt_r - WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = run && !load && (cnt_r == '0);

endmodule

// File: rtl/cd_req_arbiter.sv
// CD request arbiter: grants one of three requesters onto the HPS sector channel
// and routes the returned words. Define CD_ARB_TIMEOUT_EN to add the watchdog.
module cd_req_arbiter
  import cd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic [2:0]  req_valid,
  input  logic [15:0] req_type0,
  input  logic [15:0] req_type1,
  input  logic [15:0] req_type2,
  input  logic [10:0] req_len0,
  input  logic [10:0] req_len1,
  input  logic [10:0] req_len2,
  output logic [2:0]  req_done,
  output logic [2:0]  req_err,
  output logic [2:0]  buf_wr,
  output logic [15:0] buf_dout,
  output logic [10:0] buf_addr,
  output logic        busy,
  output logic [15:0] sd_req_type,
  output logic        sd_rd,
  input  logic        sd_ack,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr
);

  arb_state_e  state_r;
  logic [1:0]  owner_r;
  logic [10:0] len_r;
  logic [10:0] cnt_r;
  logic        ack_q_r;
  logic        bwr_q_r;

  logic        ack_rise_s;
  logic        ack_fall_s;
  logic        bwr_rise_s;
  logic [10:0] cnt_inc_s;
  logic [1:0]  grant_s;
  logic [15:0] type_sel_s;
  logic [10:0] len_sel_s;
  logic        wd_expired_s;

  assign ack_rise_s = sd_ack & ~ack_q_r;
  assign ack_fall_s = ~sd_ack & ack_q_r;
  assign bwr_rise_s = sd_buff_wr & ~bwr_q_r;
  assign cnt_inc_s  = cnt_r + 11'd1;

  // Select the winning requester's code and length for latching at grant.
  always_comb begin
    grant_s = prio_grant(req_valid);
    case (grant_s)
      REQ_AUDIO: begin
        type_sel_s = req_type2;
        len_sel_s  = req_len2;
      end
      REQ_DATA: begin
        type_sel_s = req_type1;
        len_sel_s  = req_len1;
      end
      default: begin
        type_sel_s = req_type0;
        len_sel_s  = req_len0;
      end
    endcase
  end

`ifdef CD_ARB_TIMEOUT_EN
  logic bwr_fall_s;
  logic wd_load_s;
  logic wd_run_s;

  assign bwr_fall_s = ~sd_buff_wr & bwr_q_r;
  assign wd_run_s   = (state_r == ST_REQ) || (state_r == ST_XFER);
  // Held loaded outside REQ/XFER so the full budget is available on entry.
  assign wd_load_s  = !wd_run_s || ack_rise_s || ack_fall_s || bwr_rise_s || bwr_fall_s;

  cd_arb_watchdog #(
    .WIDTH (24)
  ) u_watchdog (
    .clk_sys  (clk_sys),
    .nRESET   (nRESET),
    .load     (wd_load_s),
    .load_val (TIMEOUT_CYC - 24'd1),
    .run      (wd_run_s),
    .expired  (wd_expired_s)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign wd_expired_s   = 1'b0;
`endif

  // Arbiter FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      state_r     <= ST_IDLE;
      owner_r     <= REQ_TOC;
      len_r       <= 11'd0;
      cnt_r       <= 11'd0;
      ack_q_r     <= 1'b0;
      bwr_q_r     <= 1'b0;
      sd_rd       <= 1'b0;
      sd_req_type <= 16'h0000;
      req_done    <= 3'b000;
      req_err     <= 3'b000;
      buf_wr      <= 3'b000;
      buf_dout    <= 16'h0000;
      buf_addr    <= 11'd0;
      busy        <= 1'b0;
    end else begin
      ack_q_r  <= sd_ack;
      bwr_q_r  <= sd_buff_wr;
      req_done <= 3'b000;
      req_err  <= 3'b000;
      buf_wr   <= 3'b000;
      case (state_r)
        ST_IDLE: begin
          if (|req_valid) begin
            owner_r     <= grant_s;
            len_r       <= len_sel_s;
            sd_req_type <= type_sel_s;
            sd_rd       <= 1'b1;
            busy        <= 1'b1;
            state_r     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wd_expired_s) begin
            req_err     <= owner_mask(owner_r);
            sd_rd       <= 1'b0;
            sd_req_type <= 16'h0000;
            busy        <= 1'b0;
            state_r     <= ST_IDLE;
          end else if (ack_rise_s) begin
            sd_rd   <= 1'b0;
            cnt_r   <= 11'd0;
            state_r <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (bwr_rise_s) begin
            buf_dout <= sd_buff_dout;
            buf_addr <= cnt_r;
            buf_wr   <= owner_mask(owner_r);
            cnt_r    <= cnt_inc_s;
          end
          // A word that completes the transfer outranks a simultaneous ack drop.
          if (bwr_rise_s && (cnt_inc_s == len_r)) begin
            req_done    <= owner_mask(owner_r);
            sd_req_type <= 16'h0000;
            state_r     <= ST_FLUSH;
          end else if (ack_fall_s || wd_expired_s) begin
            req_err     <= owner_mask(owner_r);
            sd_rd       <= 1'b0;
            sd_req_type <= 16'h0000;
            busy        <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (!sd_ack) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          sd_rd       <= 1'b0;
          sd_req_type <= 16'h0000;
          busy        <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cd_req_arbiter.sv
// Bench for cd_req_arbiter: grant-priority table, directed HPS sequences and
// randomized transfers scored against a transaction-level model.
`timescale 1ns/1ps
module tb_cd_req_arbiter;

  logic        clk_sys = 1'b0;
  logic        nRESET;
  logic [2:0]  req_valid;
  logic [15:0] req_type0, req_type1, req_type2;
  logic [10:0] req_len0, req_len1, req_len2;
  logic [2:0]  req_done, req_err, buf_wr;
  logic [15:0] buf_dout;
  logic [10:0] buf_addr;
  logic        busy;
  logic [15:0] sd_req_type;
  logic        sd_rd;
  logic        sd_ack;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;

  always #5 clk_sys = ~clk_sys;

  cd_req_arbiter #(.TIMEOUT_CYC(24'd100)) dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .req_valid(req_valid),
    .req_type0(req_type0), .req_type1(req_type1), .req_type2(req_type2),
    .req_len0(req_len0), .req_len1(req_len1), .req_len2(req_len2),
    .req_done(req_done), .req_err(req_err), .buf_wr(buf_wr),
    .buf_dout(buf_dout), .buf_addr(buf_addr), .busy(busy),
    .sd_req_type(sd_req_type), .sd_rd(sd_rd), .sd_ack(sd_ack),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr)
  );

  typedef struct packed {
    logic [1:0]  owner;
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [2:0]  valid;
    logic [15:0] exp_type;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         mon_wr_q[$];
  int          done_cnt[3] = '{0, 0, 0};
  int          err_cnt[3]  = '{0, 0, 0};
  int          bad_pulse   = 0;
  int          snap_wr;
  int          snap_done[3];
  int          snap_err[3];
  logic [15:0] sent_q[$];
  logic [15:0] fixed_q[$];
  logic [15:0] tt[3];
  logic [10:0] ll[3];
  vec_t        vecs[7];

  // Output monitor, sampled on the falling edge.
  always @(negedge clk_sys) begin
    for (int i = 0; i < 3; i++) begin
      if (buf_wr[i]) mon_wr_q.push_back({2'(i), buf_addr, buf_dout});
      if (req_done[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (req_err[i]) err_cnt[i] <= err_cnt[i] + 1;
    end
    if ($countones(buf_wr) > 1 || (req_done & req_err) != 3'b000) bad_pulse <= bad_pulse + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mark();
    snap_wr = mon_wr_q.size();
    for (int i = 0; i < 3; i++) begin
      snap_done[i] = done_cnt[i];
      snap_err[i]  = err_cnt[i];
    end
    sent_q.delete();
  endtask

  function automatic logic [1:0] top_pending(input logic [2:0] p);
    for (int i = 2; i >= 0; i--) if (p[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic drive_cfg();
    req_type0 = tt[0]; req_type1 = tt[1]; req_type2 = tt[2];
    req_len0  = ll[0]; req_len1  = ll[1]; req_len2  = ll[2];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"}, 32'(sd_rd), 32'd0);
    chk({tag, "_type"}, 32'(sd_req_type), 32'd0);
    chk({tag, "_done"}, 32'(req_done), 32'd0);
    chk({tag, "_err"}, 32'(req_err), 32'd0);
    chk({tag, "_bufwr"}, 32'(buf_wr), 32'd0);
    chk({tag, "_dout"}, 32'(buf_dout), 32'd0);
    chk({tag, "_addr"}, 32'(buf_addr), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // HPS side: wait for the request, ack it, send n words, then drop ack.
  task automatic hps_serve(input logic [1:0] own, input logic [15:0] typ, input int n,
                           input logic [2:0] arrive);
    int waitc = 0;
    logic [15:0] d;
    while (sd_rd !== 1'b1 && waitc < 20) begin
      tick();
      waitc++;
    end
    chk("sd_rd_seen", 32'(sd_rd), 32'd1);
    chk("req_type", 32'(sd_req_type), 32'(typ));
    sd_ack = 1'b1;
    req_valid = (req_valid & ~(3'b001 << own)) | arrive;
    tick();
    chk("rd_drop", 32'(sd_rd), 32'd0);
    for (int i = 0; i < n; i++) begin
      d = (fixed_q.size() > 0) ? fixed_q.pop_front() : 16'($urandom);
      sent_q.push_back(d);
      sd_buff_dout = d;
      sd_buff_wr = 1'b1;
      tick();
      sd_buff_wr = 1'b0;
      sd_buff_dout = 16'($urandom);
      repeat ($urandom_range(1, 2)) tick();
    end
    sd_ack = 1'b0;
  endtask

  // Score one transfer: words min(n,len) at addr 0.., then done iff n >= len, else err.
  task automatic check_xfer(input logic [1:0] own, input int len, input int n);
    int k = (n < len) ? n : len;
    int got = mon_wr_q.size() - snap_wr;
    wr_t w;
    chk("wr_count", 32'(got), 32'(k));
    for (int i = 0; i < k && i < got; i++) begin
      w = mon_wr_q[snap_wr + i];
      chk("wr_owner", 32'(w.owner), 32'(own));
      chk("wr_addr", 32'(w.addr), 32'(i));
      chk("wr_data", 32'(w.data), 32'(sent_q[i]));
    end
    for (int r = 0; r < 3; r++) begin
      chk("done_pulses", 32'(done_cnt[r] - snap_done[r]), (r == int'(own) && n >= len) ? 32'd1 : 32'd0);
      chk("err_pulses", 32'(err_cnt[r] - snap_err[r]), (r == int'(own) && n < len) ? 32'd1 : 32'd0);
    end
    chk("pulse_shape", 32'(bad_pulse), 32'd0);
    mark();
  endtask

  initial begin
    logic [2:0] pend;
    logic [2:0] arr;
    logic [1:0] own;
    int len;
    int n;
    logic early;

    vecs[0] = '{3'b001, 16'hD000};
    vecs[1] = '{3'b010, 16'hD100};
    vecs[2] = '{3'b011, 16'hD100};
    vecs[3] = '{3'b100, 16'hD2A5};
    vecs[4] = '{3'b101, 16'hD2A5};
    vecs[5] = '{3'b110, 16'hD2A5};
    vecs[6] = '{3'b111, 16'hD2A5};

    nRESET = 1'b0; req_valid = 3'b000; sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_dout = 16'h0000;
    tt = '{16'hD000, 16'hD100, 16'hD2A5};
    ll = '{11'd2, 11'd2, 11'd2};
    drive_cfg();
    tick(); tick();
    chk_all_zero("reset");
    nRESET = 1'b1;
    tick();

    // Priority table: one grant per vector, reset between vectors.
    for (int v = 0; v < 7; v++) begin
      chk("tbl_pre_rd", 32'(sd_rd), 32'd0);
      req_valid = vecs[v].valid;
      tick();
      chk("tbl_rd", 32'(sd_rd), 32'd1);
      chk("tbl_busy", 32'(busy), 32'd1);
      chk("tbl_type", 32'(sd_req_type), 32'(vecs[v].exp_type));
      req_valid = 3'b000;
      nRESET = 1'b0;
      tick();
      chk("tbl_rst_busy", 32'(busy), 32'd0);
      nRESET = 1'b1;
    end
    tick();
    mark();

    // TOC read of two words.
    req_valid = 3'b001;
    fixed_q.push_back(16'h0101);
    fixed_q.push_back(16'h1200);
    hps_serve(2'd0, 16'hD000, 2, 3'b000);
    chk("toc_type_clr", 32'(sd_req_type), 32'd0);
    tick(); tick();
    check_xfer(2'd0, 2, 2);

    // All three pending: audio, data, TOC in turn.
    req_valid = 3'b111;
    hps_serve(2'd2, 16'hD2A5, 2, 3'b000); tick(); tick(); check_xfer(2'd2, 2, 2);
    hps_serve(2'd1, 16'hD100, 2, 3'b000); tick(); tick(); check_xfer(2'd1, 2, 2);
    hps_serve(2'd0, 16'hD000, 2, 3'b000); tick(); tick(); check_xfer(2'd0, 2, 2);

    // Surplus words after the length is reached are dropped.
    ll[0] = 11'd3; drive_cfg();
    req_valid = 3'b001;
    hps_serve(2'd0, 16'hD000, 5, 3'b000);
    chk("flush_busy", 32'(busy), 32'd1);
    tick();
    chk("flush_idle", 32'(busy), 32'd0);
    tick();
    check_xfer(2'd0, 3, 5);

    // Short data transfer, TOC waiting behind it.
    ll[0] = 11'd2; ll[1] = 11'd1176; drive_cfg();
    req_valid = 3'b011;
    hps_serve(2'd1, 16'hD100, 1000, 3'b000);
    tick();
    chk("short_err", 32'(req_err), 32'h2);
    chk("short_busy", 32'(busy), 32'd0);
    tick();
    chk("regrant_rd", 32'(sd_rd), 32'd1);
    chk("regrant_type", 32'(sd_req_type), 32'hD000);
    check_xfer(2'd1, 1176, 1000);
    hps_serve(2'd0, 16'hD000, 2, 3'b000); tick(); tick(); check_xfer(2'd0, 2, 2);

    // Reset during the fifth word of a transfer.
    ll[1] = 11'd10; drive_cfg();
    req_valid = 3'b010;
    tick();
    chk("rst_grant", 32'(sd_rd), 32'd1);
    sd_ack = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      sd_buff_dout = 16'($urandom_range(1, 65535));
      sd_buff_wr = 1'b1;
      tick();
      sd_buff_wr = 1'b0;
      tick();
    end
    nRESET = 1'b0;
    tick();
    chk_all_zero("midrst");
    nRESET = 1'b1;
    sd_ack = 1'b0;
    tick();
    chk("post_rst_grant", 32'(sd_rd), 32'd1);
    tick();
    chk("midrst_no_done", 32'(done_cnt[1] - snap_done[1]), 32'd0);
    chk("midrst_no_err", 32'(err_cnt[1] - snap_err[1]), 32'd0);
    mark();
    hps_serve(2'd1, 16'hD100, 10, 3'b000); tick(); tick(); check_xfer(2'd1, 10, 10);

    // HPS never acks.
    req_valid = 3'b100;
    tick();
    chk("wd_rd_on", 32'(sd_rd), 32'd1);
    req_valid = 3'b000;
    early = 1'b0;
`ifdef CD_ARB_TIMEOUT_EN
    repeat (99) begin
      tick();
      if (req_err != 3'b000 || sd_rd != 1'b1) early = 1'b1;
    end
    chk("wd_early", 32'(early), 32'd0);
    tick();
    chk("wd_err", 32'(req_err), 32'h4);
    chk("wd_rd_off", 32'(sd_rd), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    tick(); tick();
`else
    repeat (150) begin
      tick();
      if (req_err != 3'b000 || sd_rd != 1'b1) early = 1'b1;
    end
    chk("nowd_rd_held", 32'(early), 32'd0);
    chk("nowd_no_err", 32'(err_cnt[2] - snap_err[2]), 32'd0);
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    tick();
`endif
    mark();

    // Randomized transfers against a pending-set model.
    pend = 3'b000;
    for (int r = 0; r < 3; r++) begin
      tt[r] = {8'hD0 + 8'(r), 8'($urandom)};
      ll[r] = 11'($urandom_range(1, 6));
    end
    drive_cfg();
    for (int it = 0; it < 30; it++) begin
      if (pend == 3'b000) begin
        pend = 3'($urandom_range(1, 7));
        req_valid = pend;
      end
      own = top_pending(pend);
      len = int'(ll[own]);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1))
                                      : len + int'($urandom_range(0, 2));
      arr = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      pend = (pend & ~(3'b001 << own)) | arr;
      hps_serve(own, tt[own], n, arr);
      for (int r = 0; r < 3; r++) begin
        tt[r] = {8'hD0 + 8'(r), 8'($urandom)};
        ll[r] = 11'($urandom_range(1, 6));
      end
      drive_cfg();
      tick(); tick();
      check_xfer(own, len, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cd_req_arbiter.md
CD_REQ_ARBITER -- requirements
Module: cd_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 24'd12_000_000 (100 ms at 120 MHz): watchdog expiry, in clk_sys cycles.
REQ-002 clk_sys  in  1  sole clock; all logic is synchronous to its rising edge.
REQ-003 nRESET  in  1  reset, synchronous and active-low.
REQ-004 req_valid  in  3  per-requester pending request, level; [0]=TOC, [1]=data sector, [2]=audio sector.
REQ-005 req_type0/1/2  in  16 each  HPS request code per requester (e.g. 16'hD000, 16'hD100, 16'hD2nn).
REQ-006 req_len0/1/2  in  11 each  expected word count per requester, 1..2047.
REQ-007 req_done  out  3  one-cycle completion pulse, one bit per requester.
REQ-008 req_err  out  3  one-cycle failure pulse (short transfer or timeout), one bit per requester.
REQ-009 buf_wr  out  3  one-cycle word strobe routed to the owning requester.
REQ-010 buf_dout  out  16  registered data word; buf_addr  out  11  word index within the transfer.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 sd_req_type  out  16, sd_rd  out  1, sd_ack  in  1, sd_buff_dout  in  16, sd_buff_wr  in  1  form the HPS channel.

Function
REQ-013 States: IDLE, REQ, XFER, FLUSH; unused encodings return to IDLE.
REQ-014 IDLE: when any req_valid bit is high, grant is fixed priority, audio > data > TOC; owner, type and length latch on that edge.
REQ-015 State is REQ on the cycle after grant, with sd_rd=1 and sd_req_type=latched type.
REQ-016 Edges of sd_ack and sd_buff_wr are detected against a one-cycle registered copy of each signal.
REQ-017 REQ: on an sd_ack rising edge, sd_rd drops to 0 on the next cycle and the state goes to XFER.
REQ-018 XFER: on each sd_buff_wr rising edge, buf_dout<=sd_buff_dout, buf_addr<=word count and buf_wr[owner] pulses one cycle later; the count then increments.
REQ-019 When the count reaches the latched length, req_done[owner] pulses, sd_req_type drops to 16'h0000 and the state goes to FLUSH.
REQ-020 sd_ack falling edge in XFER with count < length: req_err[owner] pulses, sd_req_type drops to 0 and the state goes to IDLE; no done pulse.
REQ-021 FLUSH: further sd_buff_wr edges are dropped with no buf_wr; when sd_ack is low the state goes to IDLE.
REQ-022 Minimum gap between two grants is one IDLE cycle.
REQ-023 A req_valid drop mid-transfer is ignored; the transfer completes and still pulses done or err.
REQ-024 Requests arriving during busy wait; there is no queueing beyond the req_valid level.
REQ-025 done and err never both pulse for one transfer.
REQ-026 buf_addr stays at its last value outside XFER.

Reset
REQ-027 nRESET low forces IDLE and clears sd_rd, sd_req_type, req_done, req_err, buf_wr, buf_dout, buf_addr, busy, the edge registers, the count and the watchdog to 0.
REQ-028 Reset mid-transfer aborts it with no done or err pulse; sd_rd is 0 on the first cycle after the reset edge.

Configuration
REQ-029 With macro CD_ARB_TIMEOUT_EN defined, a watchdog runs in REQ and XFER only.
REQ-030 The watchdog reloads on every sd_ack or sd_buff_wr edge.
REQ-031 On watchdog expiry: req_err[owner] pulses, sd_rd=0, sd_req_type=0 and the state goes to IDLE.
REQ-032 Without CD_ARB_TIMEOUT_EN there is no watchdog logic; REQ and XFER wait indefinitely and TIMEOUT_CYC is ignored.

Structure
REQ-033 Shared package cd_pkg holds: requester index constants (REQ_TOC=0, REQ_DATA=1, REQ_AUDIO=2), the arbiter state enum, and HPS request codes (16'hD000 first/last, 16'hD100 length, 8'hD2 track-start prefix).
REQ-034 One sub-module, cd_arb_watchdog (loadable down-counter with expiry flag), is instantiated only under CD_ARB_TIMEOUT_EN.

Verification
REQ-035 TOC request type 16'hD000, len 2; HPS acks and then writes 16'h0101, 16'h1200 -> buf_wr[0] pulses twice at addr 0 and 1 with those words, req_done[0] pulses once, sd_req_type returns to 0.
REQ-036 req_valid=3'b111 together -> audio is granted first, then data, then TOC; each shows sd_rd rising one cycle after grant.
REQ-037 Data len 1176; sd_ack falls after 1000 words -> req_err[1] pulses once, no done, next grant is allowed after one IDLE cycle.
REQ-038 CD_ARB_TIMEOUT_EN with TIMEOUT_CYC=100; HPS never acks -> req_err pulses on cycle 100 after entering REQ and sd_rd=0; without the macro, sd_rd stays high.
REQ-039 nRESET low during XFER word 5 -> all outputs are 0 on the next cycle and there is no done or err pulse; a new request is granted after release.
REQ-040 Extra sd_buff_wr edges after length is reached -> no buf_wr pulses; IDLE follows sd_ack going low.
